// File: rtl/regfile_wb_queue.sv
// Write-back queue for the 32x64 register file: buffers result writes in order,
// drains one per cycle into the write port and bypasses pending values to decode.
module regfile_wb_queue #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 4,
   parameter int ZERO_REG = 31
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_addr,
   input  logic [DATA_W-1:0]         in_data,

   input  logic                      hold,
   input  logic                      flush,

   output logic                      rf_write,
   output logic [ADDR_W-1:0]         rf_wrAddr,
   output logic [DATA_W-1:0]         rf_wrData,

   input  logic [ADDR_W-1:0]         byp_addrA,
   output logic                      byp_hitA,
   output logic [DATA_W-1:0]         byp_dataA,
   input  logic [ADDR_W-1:0]         byp_addrB,
   output logic                      byp_hitB,
   output logic [DATA_W-1:0]         byp_dataB,

   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);

   localparam int                PTR_W     = $clog2(DEPTH);
   localparam int                CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   logic              push;
   logic              drain;

   logic [ADDR_W-1:0] byp_addr [2];
   logic              byp_hit  [2];
   logic [DATA_W-1:0] byp_data [2];

   // ------------------------------------------------------------------
   // Handshake and drain
   // ------------------------------------------------------------------
   assign in_ready = (count_q < FULL_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;

   // A zero-register write completes the handshake but never occupies a slot.
   assign push  = in_valid && in_ready && !flush && (in_addr != ZERO_ADDR);
   assign drain = !empty && !hold && !flush;

   assign rf_write  = drain;
   assign rf_wrAddr = empty ? '0 : addr_q[rd_ptr_q];
   assign rf_wrData = empty ? '0 : data_q[rd_ptr_q];

   // ------------------------------------------------------------------
   // Pointer / occupancy next state
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (drain) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples pre-edge values regardless of block evaluation order.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Entry storage
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the array is small and flop-based, so it is cleared on reset;
         // this keeps head/bypass outputs free of X before the first write.
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else if (push) begin
         addr_q[wr_ptr_q] <= in_addr;
         data_q[wr_ptr_q] <= in_data;
      end
   end

   // ------------------------------------------------------------------
   // Bypass: scan oldest to youngest so the last match wins
   // ------------------------------------------------------------------
   assign byp_addr[0] = byp_addrA;
   assign byp_addr[1] = byp_addrB;

   always_comb begin
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int p = 0; p < 2; p++) begin
         byp_hit[p]  = 1'b0;
         byp_data[p] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == byp_addr[p]) &&
                (byp_addr[p] != ZERO_ADDR)) begin
               byp_hit[p]  = 1'b1;
               byp_data[p] = data_q[idx];
            end
         end
      end
   end

   assign byp_hitA  = byp_hit[0];
   assign byp_dataA = byp_data[0];
   assign byp_hitB  = byp_hit[1];
   assign byp_dataB = byp_data[1];

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: accepted writes go into an expected
// queue, and a negedge monitor pops and compares every register-file commit.
module tb_regfile_wb_queue;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic              hold;
   logic              flush;
   logic              rf_write;
   logic [ADDR_W-1:0] rf_wrAddr;
   logic [DATA_W-1:0] rf_wrData;
   logic [ADDR_W-1:0] byp_addrA;
   logic              byp_hitA;
   logic [DATA_W-1:0] byp_dataA;
   logic [ADDR_W-1:0] byp_addrB;
   logic              byp_hitB;
   logic [DATA_W-1:0] byp_dataB;
   logic [$clog2(DEPTH):0] count;
   logic              empty;

   wr_t exp_q[$];
   int  errors = 0;
   int  checks = 0;
   logic acc;

   regfile_wb_queue #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(31)
   ) dut (
      .clk(clk), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .hold(hold), .flush(flush),
      .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
      .byp_addrA(byp_addrA), .byp_hitA(byp_hitA), .byp_dataA(byp_dataA),
      .byp_addrB(byp_addrB), .byp_hitB(byp_hitB), .byp_dataB(byp_dataB),
      .count(count), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one write for a single cycle; the handshake outcome is in_ready as
   // seen during that cycle, and only real (non-zero, unflushed) writes are expected.
   task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       output logic accepted);
      logic fl;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      #1;
      accepted = in_ready;
      fl       = flush;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (accepted && !fl && a != 5'd31) exp_q.push_back('{addr: a, data: d});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard monitor: every commit must match the oldest outstanding write.
   always @(negedge clk) begin
      if (rst_n && rf_write) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write (t=%0t)",
                     rf_wrAddr, rf_wrData, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("commit_addr", 64'(rf_wrAddr), 64'(e.addr));
            check("commit_data", rf_wrData, e.data);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_addr   = '0;
      in_data   = '0;
      hold      = 1'b0;
      flush     = 1'b0;
      byp_addrA = 5'd3;
      byp_addrB = 5'd0;

      // Reset state
      #2;
      check("rst_rf_write", 64'(rf_write), 64'd0);
      check("rst_wraddr",   64'(rf_wrAddr), 64'd0);
      check("rst_wrdata",   rf_wrData, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_empty",    64'(empty), 64'd1);
      check("rst_count",    64'(count), 64'd0);
      check("rst_hitA",     64'(byp_hitA), 64'd0);
      check("rst_dataA",    byp_dataA, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single write, one-cycle latency
      push(5'd3, 64'h1122334455667788, acc);
      check("t1_rf_write", 64'(rf_write), 64'd1);
      check("t1_wraddr",   64'(rf_wrAddr), 64'd3);
      check("t1_wrdata",   rf_wrData, 64'h1122334455667788);
      tick(1);
      check("t1_empty", 64'(empty), 64'd1);
      check("t1_count", 64'(count), 64'd0);

      // Fill under hold, reject fifth, then drain in order
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) push(5'(i), 64'(i * 16), acc);
      check("t2_count",    64'(count), 64'd4);
      check("t2_in_ready", 64'(in_ready), 64'd0);
      push(5'd5, 64'h50, acc);
      check("t2_push5_rejected", 64'(acc), 64'd0);
      check("t2_count_full",     64'(count), 64'd4);
      hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check("t2_drain_write", 64'(rf_write), 64'd1);
         check("t2_drain_addr",  64'(rf_wrAddr), 64'(i));
         tick(1);
      end
      check("t2_in_ready_after", 64'(in_ready), 64'd1);
      check("t2_empty_after",    64'(empty), 64'd1);

      // Youngest-match bypass
      hold = 1'b1;
      push(5'd7, 64'hA, acc);
      push(5'd7, 64'hB, acc);
      byp_addrA = 5'd7;
      byp_addrB = 5'd8;
      #1;
      check("t3_hitA",  64'(byp_hitA), 64'd1);
      check("t3_dataA", byp_dataA, 64'hB);
      check("t3_hitB",  64'(byp_hitB), 64'd0);
      check("t3_dataB", byp_dataB, 64'd0);
      hold = 1'b0;
      tick(3);
      check("t3_empty", 64'(empty), 64'd1);

      // Zero-register write is consumed and never visible
      push(5'd31, 64'hFFFF, acc);
      check("t4_accepted", 64'(acc), 64'd1);
      check("t4_count",    64'(count), 64'd0);
      check("t4_rf_write", 64'(rf_write), 64'd0);
      byp_addrA = 5'd31;
      #1;
      check("t4_hitA_zero", 64'(byp_hitA), 64'd0);
      tick(2);

      // Back-to-back pushes with concurrent drain, pointers wrap twice
      for (int i = 0; i < 10; i++) begin
         push(5'(i), 64'h100 + 64'(i), acc);
         check("t5_accepted", 64'(acc), 64'd1);
         check("t5_count",    64'(count), 64'd1);
         check("t5_rf_write", 64'(rf_write), 64'd1);
      end
      tick(1);
      check("t5_empty", 64'(empty), 64'd1);

      // Flush under hold with a concurrent push
      hold = 1'b1;
      push(5'd11, 64'h11, acc);
      push(5'd12, 64'h12, acc);
      push(5'd13, 64'h13, acc);
      flush = 1'b1;
      push(5'd9, 64'h99, acc);
      flush = 1'b0;
      exp_q.delete();
      check("t6_flush_push_acc", 64'(acc), 64'd1);
      check("t6_count", 64'(count), 64'd0);
      check("t6_empty", 64'(empty), 64'd1);
      hold = 1'b0;
      tick(3);

      // Flush overrides drain even with hold released
      hold = 1'b1;
      push(5'd21, 64'h21, acc);
      push(5'd22, 64'h22, acc);
      hold  = 1'b0;
      flush = 1'b1;
      #1;
      check("t6b_no_write_flush", 64'(rf_write), 64'd0);
      tick(1);
      flush = 1'b0;
      exp_q.delete();
      check("t6b_empty", 64'(empty), 64'd1);
      tick(2);

      // Asynchronous reset mid-operation
      hold = 1'b1;
      push(5'd1, 64'hAA, acc);
      push(5'd2, 64'hBB, acc);
      hold = 1'b0;
      #1;
      check("t7_write_before_rst", 64'(rf_write), 64'd1);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("t7_write_in_rst", 64'(rf_write), 64'd0);
      check("t7_count_in_rst", 64'(count), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("t7_count_after", 64'(count), 64'd0);
      check("t7_empty_after", 64'(empty), 64'd1);

      // Queue works after reset
      push(5'd4, 64'hCAFE, acc);
      tick(2);
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
